// File: rtl/lcd_line_writer.sv
// Paints a 16-character ASCII line onto row 1 of an HD44780-style LCD over an 8-bit bus.
// Runs the power-up init once after reset, then refreshes frames and pulses frame_done per frame.
module lcd_line_writer #(
  parameter int unsigned POWERUP_CYC  = 750000,
  parameter int unsigned E_HIGH_CYC   = 12,
  parameter int unsigned CMD_WAIT_CYC = 2000,
  parameter int unsigned CLR_WAIT_CYC = 82000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] line_in,
  input  logic         refresh_en,
  output logic [7:0]   lcd_data,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic         lcd_e,
  output logic         init_done,
  output logic         frame_done
);

  typedef enum logic [2:0] {
    StPwrWait,
    StSetup,
    StEHi,
    StWait,
    StFrameEnd,
    StIdle
  } state_e;

  state_e         state;
  logic [31:0]    cnt;
  logic [4:0]     idx;
  logic [127:0]   snap;
  logic [31:0]    wait_len;
  logic           wait_last;
  logic           start_frame;

  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    init_cmd = 8'h38;
      2'd1:    init_cmd = 8'h0C;
      2'd2:    init_cmd = 8'h06;
      default: init_cmd = 8'h01;
    endcase
  endfunction

  // Only the fourth init command (clear) needs the long settle time.
  assign wait_len  = (!init_done && idx == 5'd3) ? CLR_WAIT_CYC : CMD_WAIT_CYC;
  assign wait_last = (state == StWait) && (cnt == wait_len - 32'd1);

  assign start_frame = (wait_last && !init_done && idx == 5'd3) ||
                       ((state == StFrameEnd || state == StIdle) && refresh_en);

  assign lcd_rw = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StPwrWait;
      cnt        <= '0;
      idx        <= '0;
      snap       <= '0;
      lcd_data   <= 8'h00;
      lcd_rs     <= 1'b0;
      lcd_e      <= 1'b0;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        StPwrWait: begin
          if (cnt == POWERUP_CYC - 32'd1) begin
            cnt      <= '0;
            idx      <= '0;
            lcd_rs   <= 1'b0;
            lcd_data <= init_cmd(2'd0);
            state    <= StSetup;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        StSetup: begin
          lcd_e <= 1'b1;
          cnt   <= '0;
          state <= StEHi;
        end
        StEHi: begin
          if (cnt == E_HIGH_CYC - 32'd1) begin
            lcd_e <= 1'b0;
            cnt   <= '0;
            state <= StWait;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        StWait: begin
          if (wait_last) begin
            cnt <= '0;
            if (!init_done) begin
              if (idx != 5'd3) begin
                idx      <= idx + 5'd1;
                lcd_data <= init_cmd(idx[1:0] + 2'd1);
                state    <= StSetup;
              end
            end else if (idx == 5'd16) begin
              frame_done <= 1'b1;
              state      <= StFrameEnd;
            end else begin
              // Characters are peeled off the snapshot MSB-first so index 0 is leftmost.
              idx      <= idx + 5'd1;
              lcd_rs   <= 1'b1;
              lcd_data <= snap[127:120];
              snap     <= {snap[119:0], 8'h00};
              state    <= StSetup;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        StFrameEnd: begin
          if (!refresh_en) state <= StIdle;
        end
        StIdle: begin
        end
        default: state <= StPwrWait;
      endcase

      // Frame start overrides the per-state updates above; the snapshot keeps the frame untorn.
      if (start_frame) begin
        state     <= StSetup;
        cnt       <= '0;
        idx       <= '0;
        lcd_rs    <= 1'b0;
        lcd_data  <= 8'h80;
        snap      <= line_in;
        init_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lcd_line_writer.sv
// Self-checking bench for lcd_line_writer: random lines against a write-sequence model.
module tb_lcd_line_writer;

  localparam int unsigned PWR = 10;
  localparam int unsigned EH  = 2;
  localparam int unsigned CW  = 3;
  localparam int unsigned CLW = 5;
  localparam int unsigned WR  = 1 + EH + CW;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] line_in = '0;
  logic         refresh_en = 1'b1;
  logic [7:0]   lcd_data;
  logic         lcd_rs, lcd_rw, lcd_e, init_done, frame_done;

  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;
  int          fd_cnt = 0;
  logic [8:0]  prev_w = '0;
  logic        prev_e = 1'b0;
  logic        prev_rst = 1'b1;
  logic        pend = 1'b0;

  lcd_line_writer #(
    .POWERUP_CYC (PWR),
    .E_HIGH_CYC  (EH),
    .CMD_WAIT_CYC(CW),
    .CLR_WAIT_CYC(CLW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .line_in   (line_in),
    .refresh_en(refresh_en),
    .lcd_data  (lcd_data),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_e     (lcd_e),
    .init_done (init_done),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // cyc = cycles since reset release
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h (cyc %0d)", tag, got, want, cyc);
    end
  endtask

  // Advance one cycle, sample at the falling edge and check bus stability.
  task automatic step();
    @(negedge clk);
    if (pend) chk("setup_then_e", {31'd0, lcd_e}, 32'd1);
    pend = 1'b0;
    if (!rst && !prev_rst && {lcd_rs, lcd_data} !== prev_w) begin
      chk("bus_change_e_low", {30'd0, prev_e, lcd_e}, 32'd0);
      pend = 1'b1;
    end
    if (!rst && frame_done === 1'b1) fd_cnt++;
    prev_w   = {lcd_rs, lcd_data};
    prev_e   = lcd_e;
    prev_rst = rst;
  endtask

  task automatic wait_until(input int unsigned t);
    while (cyc < t) step();
  endtask

  task automatic get_write(output logic [8:0] w, output int unsigned rise);
    int n;
    n = 0;
    while (lcd_e !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    chk("e_rise_timeout", (n < 300) ? 32'd1 : 32'd0, 32'd1);
    w    = {lcd_rs, lcd_data};
    rise = cyc;
    n    = 0;
    while (lcd_e === 1'b1 && n < 50) begin
      step();
      n++;
    end
    chk("e_high_len", n, EH);
  endtask

  function automatic logic [127:0] rand_line();
    logic [127:0] l;
    for (int k = 0; k < 16; k++) l = {l[119:0], 8'($urandom_range(32, 126))};
    return l;
  endfunction

  task automatic do_init();
    logic [8:0]  w;
    int unsigned r;
    logic [7:0]  cmds [4];
    cmds = '{8'h38, 8'h0C, 8'h06, 8'h01};
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < int'(PWR); c++) begin
      step();
      chk("pwr_wait_outs", {19'd0, lcd_data, lcd_rs, lcd_rw, lcd_e, init_done, frame_done}, 0);
    end
    for (int n = 0; n < 4; n++) begin
      get_write(w, r);
      chk("init_rise", r, PWR + 1 + WR * n);
      chk("init_cmd", w, {1'b0, cmds[n]});
    end
    wait_until(PWR + 3 * WR + 1 + EH + CLW - 1);
    chk("init_done_low", init_done, 0);
    step();
    chk("init_done_rise", {init_done, lcd_e, lcd_rs, lcd_data}, {3'b100, 8'h80});
  endtask

  task automatic check_frame(input logic [127:0] ln, input int unsigned s, input int chg_j,
                             input logic [127:0] chg_ln, input int stop_j);
    logic [8:0]  w;
    int unsigned r;
    for (int j = 0; j < 17; j++) begin
      get_write(w, r);
      chk("frame_rise", r, s + 1 + WR * j);
      if (j == 0) chk("frame_addr", w, {1'b0, 8'h80});
      else        chk("frame_char", w, {1'b1, 8'(ln >> (8 * (16 - j)))});
      if (j == chg_j)  line_in = chg_ln;
      if (j == stop_j) refresh_en = 1'b0;
    end
    wait_until(s + 17 * WR);
    chk("frame_done", frame_done, 1);
    step();
    chk("frame_done_pulse", frame_done, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] ln1, ln2, ln3, ln4, ln5;
    logic [8:0]   w;
    int unsigned  r, s4;
    int           ecnt, n;
    ln1 = "   Phan Minh Nha";
    ln2 = rand_line();
    ln3 = rand_line();
    ln4 = rand_line();
    ln5 = rand_line();
    line_in = ln1;
    refresh_en = 1'b1;
    repeat (2) step();
    chk("reset_outs", {19'd0, lcd_data, lcd_rs, lcd_rw, lcd_e, init_done, frame_done}, 0);

    do_init();
    check_frame(ln1, 36, 16, ln2, -1);
    check_frame(ln2, 36 + 103, 6, ln3, -1);
    check_frame(ln3, 36 + 2 * 103, -1, '0, 3);

    ecnt = 0;
    for (int c = 0; c < 25; c++) begin
      step();
      if (lcd_e === 1'b1) ecnt++;
    end
    chk("idle_no_e", ecnt, 0);
    chk("idle_init_done", init_done, 1);

    refresh_en = 1'b1;
    line_in = ln4;
    s4 = cyc + 1;
    get_write(w, r);
    chk("resume_rise", r, s4 + 1);
    chk("resume_addr", w, {1'b0, 8'h80});
    get_write(w, r);
    chk("resume_char0", w, {1'b1, ln4[127:120]});

    n = 0;
    while (lcd_e !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    chk("e_before_rst", lcd_e, 1);
    rst = 1'b1;
    #1;
    chk("rst_async", {21'd0, lcd_e, lcd_data, lcd_rs, init_done, frame_done}, 0);
    line_in = ln5;
    repeat (3) step();
    do_init();
    check_frame(ln5, 36, -1, '0, -1);
    chk("frame_done_count", fd_cnt, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcd_line_writer.md
# lcd_line_writer

Downstream consumer of the 16-character marquee window. Takes the 128-bit ASCII line (16 chars, leftmost char in bits [127:120]) and continuously paints it onto row 1 of an HD44780-compatible character LCD over an 8-bit write-only bus. It performs the power-up init sequence once after reset, then loops frame refreshes, and pulses `frame_done` after each complete frame so the marquee shifter can be stepped once per displayed frame.

## Interface
- `POWERUP_CYC`, 750000: cycles of idle wait after reset before the first command (15 ms @ 50 MHz).
- `E_HIGH_CYC`, 12: cycles `lcd_e` is held high per write.
- `CMD_WAIT_CYC`, 2000: cycles waited after `lcd_e` falls, for all writes except clear.
- `CLR_WAIT_CYC`, 82000: cycles waited after `lcd_e` falls for the clear command (0x01).
- `clk`  input  1  single system clock; all state on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `line_in`  input  128  16 ASCII chars; char k (k=0 leftmost) = `line_in[127-8k -: 8]`.
- `refresh_en`  input  1  high: keep refreshing; low: stop at next frame boundary.
- `lcd_data`  output  8  LCD DB7..DB0.
- `lcd_rs`  output  1  0 = command, 1 = character data.
- `lcd_rw`  output  1  tied 0 (write only).
- `lcd_e`  output  1  LCD enable strobe.
- `init_done`  output  1  high once init sequence complete; stays high until reset.
- `frame_done`  output  1  one-cycle pulse at the end of each full frame.

## Operation
- Reset values: `lcd_data`=0x00, `lcd_rs`=0, `lcd_rw`=0, `lcd_e`=0, `init_done`=0, `frame_done`=0; state PWR_WAIT, all counters 0.
- Top FSM: PWR_WAIT -> INIT (4 commands) -> FRAME (address + 16 chars) -> FRAME_END -> FRAME or IDLE.
- PWR_WAIT: count POWERUP_CYC cycles, outputs at reset values.
- INIT: commands in order 0x38 (8-bit, 2-line, 5x8), 0x0C (display on, cursor off), 0x06 (increment, no shift), 0x01 (clear, uses CLR_WAIT_CYC). `lcd_rs`=0.
- FRAME: command 0x80 (DDRAM addr 0, rs=0), then chars 0..15 with rs=1. `line_in` is latched into an internal 128-bit register in the cycle the 0x80 setup phase starts; all 16 chars come from that snapshot, so changes to `line_in` mid-frame do not tear the frame.
- Each write (sub-FSM): SETUP 1 cycle (`lcd_data`/`lcd_rs` driven, `lcd_e`=0) -> E_HI E_HIGH_CYC cycles (`lcd_e`=1) -> WAIT W cycles (`lcd_e`=0), W = CMD_WAIT_CYC or CLR_WAIT_CYC. `lcd_data`/`lcd_rs` hold their value from SETUP until the next write's SETUP.
- `init_done` rises in the cycle the first FRAME 0x80 SETUP begins.
- FRAME_END: 1 cycle, `frame_done`=1. Next cycle: if `refresh_en`=1, SETUP of next 0x80; else IDLE.
- IDLE: outputs hold last values, `lcd_e`=0; on `refresh_en`=1 go to FRAME SETUP next cycle.
- `refresh_en` is only sampled in FRAME_END and IDLE; deasserting mid-frame finishes the frame.
- `rst` at any time (including mid-E pulse) forces reset values immediately and restarts from PWR_WAIT, including full re-init.

## Timing
- Write length: 1 + E_HIGH_CYC + W cycles.
- Init length after `rst` release: POWERUP_CYC + 3*(1+E_HIGH_CYC+CMD_WAIT_CYC) + (1+E_HIGH_CYC+CLR_WAIT_CYC).
- Frame period (continuous refresh): 17*(1+E_HIGH_CYC+CMD_WAIT_CYC) + 1 cycles between `frame_done` pulses.
- Data setup before E rise: 1 cycle; hold after E fall: ≥ W cycles.

## Test plan
Use POWERUP_CYC=10, E_HIGH_CYC=2, CMD_WAIT_CYC=3, CLR_WAIT_CYC=5 (write = 6 cycles, clear = 8, init = 36, frame = 103).
- Reset then release -> all outputs 0 for 10 cycles; E pulses carry 0x38, 0x0C, 0x06, 0x01 with rs=0, each E high exactly 2 cycles; `init_done` rises at cycle 36.
- `line_in`="   Phan Minh Nha" -> after 0x80 (rs=0), 16 E pulses with rs=1 deliver 0x20,0x20,0x20,0x50,... in order; `frame_done` pulses once, 103 cycles apart in steady state.
- Change `line_in` during char 5 of a frame -> remaining chars of that frame from old snapshot; next frame shows new value.
- `refresh_en`=0 mid-frame -> frame completes, `frame_done` pulses, no further E pulses; reassert -> 0x80 SETUP next cycle.
- Assert `rst` while `lcd_e`=1 -> `lcd_e`, `lcd_data`, `init_done` go 0 asynchronously; full init replays after release.
- Check `lcd_data`/`lcd_rs` never change while `lcd_e`=1 or during WAIT across a whole run.
